// File: rtl/shared_port_arbiter_pkg.sv
// Shared definitions for the burst-locked two-requester port arbiter:
// path-select encodings, FSM state type and statistics counter width.
package shared_port_pkg;

  localparam int STATS_W = 16;

  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_REQ0 = 2'd1;
  localparam logic [1:0] SEL_REQ1 = 2'd2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic logic [1:0] sel_of(input logic winner);
    return winner ? SEL_REQ1 : SEL_REQ0;
  endfunction

endpackage

// File: rtl/shared_port_arbiter_burst_counter.sv
// Loadable beat down-counter; holds the beats remaining minus one for the
// burst in flight. Load wins over decrement, and it never wraps below zero.
module arb_burst_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shared_port_arbiter.sv
// Burst-locked round-robin arbiter sharing one write port between two streams.
// Define ARB_STATS_EN to add the per-requester grant_cnt_0/1 statistics ports.
module shared_port_arbiter
  import shared_port_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_0,
  input  logic             req_1,
  input  logic [LEN_W-1:0] len_0,
  input  logic [LEN_W-1:0] len_1,
  input  logic             valid_0,
  input  logic             valid_1,
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  output logic             ready_0,
  output logic             ready_1,
  output logic             grant_0,
  output logic             grant_1,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             burst_last,
  output logic [0:0]       dbg_state_o
`ifdef ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] grant_cnt_0,
  output logic [STATS_W-1:0] grant_cnt_1
`endif
);

  // Handshake: a beat moves when out_valid && out_ready; the owner's ready is
  // out_ready passed straight through, the non-owner always sees ready low.
  arb_state_e state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] grant_q, grant_d;
  logic       ptr_q, ptr_d;

  logic cnt_zero, xfer, last_xfer, arb_open, do_grant, winner, ptr_nxt;
  logic [LEN_W-1:0] win_len;

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    ready_0   = 1'b0;
    ready_1   = 1'b0;
    if (grant_q[0]) begin
      out_valid = valid_0;
      out_data  = data_0;
      ready_0   = out_ready;
    end else if (grant_q[1]) begin
      out_valid = valid_1;
      out_data  = data_1;
      ready_1   = out_ready;
    end
  end

  assign xfer       = out_valid && out_ready;
  assign last_xfer  = xfer && cnt_zero;
  assign burst_last = out_valid && cnt_zero;

  // The pointer flips on the final beat and the same-edge re-arbitration
  // already uses the flipped value, so back-to-back bursts see fresh priority.
  assign ptr_nxt  = ptr_q ^ last_xfer;
  assign arb_open = (state_q == IDLE) || last_xfer;
  assign winner   = (req_0 && req_1) ? ptr_nxt : req_1;
  assign do_grant = arb_open && (req_0 || req_1);
  assign win_len  = winner ? len_1 : len_0;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    ptr_d   = ptr_nxt;
    if (do_grant) begin
      state_d = BURST;
      sel_d   = sel_of(winner);
      grant_d = winner ? 2'b10 : 2'b01;
    end else if (last_xfer) begin
      state_d = IDLE;
      sel_d   = SEL_IDLE;
      grant_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  arb_burst_counter #(
    .LEN_W (LEN_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (do_grant),
    .len_i  (win_len),
    .dec_i  (xfer),
    .zero_o (cnt_zero)
  );

  assign sel         = sel_q;
  assign grant_0     = grant_q[0];
  assign grant_1     = grant_q[1];
  assign dbg_state_o = state_q;

`ifdef ARB_STATS_EN
  localparam logic [STATS_W-1:0] STATS_ONE = STATS_W'(1);
  logic [STATS_W-1:0] gcnt0_q, gcnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (do_grant && !winner && (gcnt0_q != '1)) gcnt0_q <= gcnt0_q + STATS_ONE;
      if (do_grant && winner && (gcnt1_q != '1))  gcnt1_q <= gcnt1_q + STATS_ONE;
    end
  end

  assign grant_cnt_0 = gcnt0_q;
  assign grant_cnt_1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Bench for shared_port_arbiter: directed reset/ordering cases, then random
// traffic against a burst-level reference model with an expected-beat queue.
module tb_shared_port_arbiter;
  import shared_port_pkg::*;

  localparam int WIDTH = 16;
  localparam int LEN_W = 8;
  localparam int EW    = 2 + WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_0, req_1;
  logic [LEN_W-1:0] len_0, len_1;
  logic             valid_0, valid_1;
  logic [WIDTH-1:0] data_0, data_1;
  logic             ready_0, ready_1, grant_0, grant_1;
  logic [1:0]       sel;
  logic             out_valid, out_ready, burst_last;
  logic [WIDTH-1:0] out_data;
  logic [0:0]       dbg_state_o;
`ifdef ARB_STATS_EN
  logic [15:0]      grant_cnt_0, grant_cnt_1;
`endif

  shared_port_arbiter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1), .len_0(len_0), .len_1(len_1),
    .valid_0(valid_0), .valid_1(valid_1), .data_0(data_0), .data_1(data_1),
    .ready_0(ready_0), .ready_1(ready_1), .grant_0(grant_0), .grant_1(grant_1),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .burst_last(burst_last), .dbg_state_o(dbg_state_o)
`ifdef ARB_STATS_EN
    , .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  bit               m_busy;
  int               m_owner, m_rem, m_ptr;
  logic [1:0]       m_sel;
  bit               mon_en;
  bit               pend [2];
  int               plen [2];
  int               gcnt [2];
  logic [WIDTH-1:0] pend_q [2][$];
  logic [WIDTH-1:0] cur_q  [2][$];
  logic [EW-1:0]    exp_q[$];

  task automatic reset_model();
    m_busy = 0; m_owner = 0; m_rem = 0; m_ptr = 0; m_sel = SEL_IDLE;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 0; plen[r] = 0; gcnt[r] = 0;
      pend_q[r].delete(); cur_q[r].delete();
    end
    exp_q.delete();
  endtask

  task automatic drive_idle();
    req_0 = 0; req_1 = 0; len_0 = '0; len_1 = '0;
    valid_0 = 0; valid_1 = 0; data_0 = '0; data_1 = '0; out_ready = 0;
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst_n = 0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    reset_model();
  endtask

  // A granted burst becomes a list of expected beats, tagged with the path
  // select and whether the beat should close the burst.
  task automatic model_grant(input int w);
    logic [1:0] s;
    m_busy  = 1;
    m_owner = w;
    m_rem   = plen[w] + 1;
    cur_q[w] = pend_q[w];
    pend[w] = 0;
    s = (w == 0) ? SEL_REQ0 : SEL_REQ1;
    for (int i = 0; i < cur_q[w].size(); i++)
      exp_q.push_back({s, cur_q[w][i], (i == cur_q[w].size() - 1) ? 1'b1 : 1'b0});
    gcnt[w]++;
  endtask

  task automatic model_step();
    bit own_valid;
    own_valid = (m_owner == 0) ? valid_0 : valid_1;
    if (m_busy && own_valid && out_ready) begin
      void'(cur_q[m_owner].pop_front());
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_ptr  = 1 - m_ptr;
      end
    end
    if (!m_busy && (req_0 || req_1)) begin
      if (req_0 && req_1) model_grant(m_ptr);
      else                model_grant(req_1 ? 1 : 0);
    end
    m_sel = !m_busy ? SEL_IDLE : (m_owner == 0 ? SEL_REQ0 : SEL_REQ1);
  endtask

  task automatic new_burst(input int r);
    plen[r] = ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 4));
    pend_q[r].delete();
    for (int i = 0; i <= plen[r]; i++) pend_q[r].push_back(WIDTH'($urandom));
    pend[r] = 1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit force_both, input bit allow_new);
    for (int r = 0; r < 2; r++)
      if (!pend[r] && allow_new && (force_both || $urandom_range(0, 3) == 0)) new_burst(r);
    req_0   = pend[0];
    req_1   = pend[1];
    len_0   = pend[0] ? LEN_W'(plen[0]) : LEN_W'($urandom);
    len_1   = pend[1] ? LEN_W'(plen[1]) : LEN_W'($urandom);
    valid_0 = ($urandom_range(0, 3) != 0);
    valid_1 = ($urandom_range(0, 3) != 0);
    data_0  = (m_busy && m_owner == 0 && cur_q[0].size() > 0) ? cur_q[0][0] : WIDTH'($urandom);
    data_1  = (m_busy && m_owner == 1 && cur_q[1].size() > 0) ? cur_q[1][0] : WIDTH'($urandom);
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_engine(input int ncyc, input bit force_both);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      model_step();
      #1;
      drive(force_both, 1'b1);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((m_busy || pend[0] || pend[1]) && n < 4000) begin
      @(posedge clk);
      model_step();
      #1;
      drive(1'b0, 1'b0);
      n++;
    end
    check({tag, "_drain_done"}, {31'd0, m_busy || pend[0] || pend[1]}, 32'd0);
    @(negedge clk);
    check({tag, "_exp_q_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef ARB_STATS_EN
    check({tag, "_grant_cnt_0"}, {16'd0, grant_cnt_0}, gcnt[0]);
    check({tag, "_grant_cnt_1"}, {16'd0, grant_cnt_1}, gcnt[1]);
`else
    check({tag, "_grant_total_seen"}, {31'd0, (gcnt[0] + gcnt[1]) > 0}, 32'd1);
`endif
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic          exp_ov;
    logic [1:0]    exp_g;
    logic [EW-1:0] e;
    if (mon_en && rst_n) begin
      exp_ov = m_busy && ((m_owner == 0) ? valid_0 : valid_1);
      exp_g  = (m_sel == SEL_REQ0) ? 2'b01 : (m_sel == SEL_REQ1) ? 2'b10 : 2'b00;
      check("sel", sel, m_sel);
      check("grant", {grant_1, grant_0}, exp_g);
      check("ready", {ready_1, ready_0}, exp_g & {out_ready, out_ready});
      check("out_valid", out_valid, exp_ov);
      check("burst_last", burst_last, exp_ov && (m_rem == 1));
      check("dbg_state", dbg_state_o, m_busy);
      if (out_valid && out_ready) begin
        check("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", {sel, out_data, burst_last}, e);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  logic [1:0] exp_sel_seq [5];
  logic       exp_last_seq[5];

  initial begin
    exp_sel_seq  = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    exp_last_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    mon_en = 0;
    reset_model();

    // Reset state with active inputs: every output must read zero.
    rst_n = 0;
    drive_idle();
    req_0 = 1; req_1 = 1; valid_0 = 1; valid_1 = 1; out_ready = 1;
    data_0 = 16'hA5A5; data_1 = 16'h5A5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sel", sel, 2'd0);
    check("rst_grant", {grant_1, grant_0}, 2'b00);
    check("rst_ready", {ready_1, ready_0}, 2'b00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0);
    check("rst_burst_last", burst_last, 1'b0);

    // Simultaneous requests with len 1: sel 1,1,2,2,0 and no idle gap.
    do_reset();
    req_0 = 1; req_1 = 1; len_0 = 8'd1; len_1 = 8'd1;
    valid_0 = 1; valid_1 = 1; out_ready = 1; data_0 = 16'h1111; data_1 = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) req_0 = 0;
      if (i == 2) req_1 = 0;
      @(negedge clk);
      check($sformatf("simul_sel_%0d", i), sel, exp_sel_seq[i]);
      check($sformatf("simul_last_%0d", i), burst_last, exp_last_seq[i]);
    end

    // Async reset during beat 2 of a 4-beat burst, then requester 1 alone.
    req_0 = 1; len_0 = 8'd3; valid_0 = 1; valid_1 = 0; out_ready = 1;
    @(posedge clk);
    #1 req_0 = 0;
    @(negedge clk);
    check("mid_grant0", grant_0, 1'b1);
    @(posedge clk);
    #2;
    check("mid_beat2_valid", out_valid, 1'b1);
    rst_n = 0;
    #1;
    check("mid_rst_sel", sel, 2'd0);
    check("mid_rst_grant", {grant_1, grant_0}, 2'b00);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_ready0", ready_0, 1'b0);
    @(negedge clk);
    rst_n = 1;
    req_1 = 1; len_1 = 8'd0; valid_1 = 1; data_1 = 16'hBEEF;
    @(posedge clk);
    #1 req_1 = 0;
    @(negedge clk);
    check("post_rst_grant1", {grant_1, grant_0}, 2'b10);
    check("post_rst_sel", sel, 2'd2);
    check("post_rst_data", out_data, 16'hBEEF);
    check("post_rst_last", burst_last, 1'b1);

    // Fairness: both requesters always pending.
    do_reset();
    mon_en = 1;
    drive(1'b1, 1'b1);
    run_engine(300, 1'b1);
    drain("fair");
    check_stats("fair");

    // Random traffic with back-pressure, valid gaps and long bursts.
    do_reset();
    mon_en = 1;
    drive(1'b0, 1'b1);
    run_engine(3000, 1'b0);
    drain("rand");
    check_stats("rand");
    mon_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
